// File: rtl/fsm_seq_monitor.sv
// Checker for the run controller's 2-bit state bus. It tracks the legal IDLE->RUN->DONE->IDLE cycle,
// pulses on run start and run completion, counts completed runs and latches the first illegal transition.
module fsm_seq_monitor #(
    parameter logic [1:0] IDLE  = 2'b00,
    parameter logic [1:0] RUN   = 2'b01,
    parameter logic [1:0] DONE  = 2'b10,
    parameter int         CNT_W = 8,
    parameter bit         SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       state_in,
    input  logic             clear_err,
    input  logic             count_clr,
    output logic             run_start,
    output logic             run_done,
    output logic [CNT_W-1:0] run_count,
    output logic             err,
    output logic [3:0]       err_info,
    output logic [2:0]       mon_state
);

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        M_IDLE = 3'd1,
        M_RUN  = 3'd2,
        M_DONE = 3'd3,
        FAULT  = 3'd4
    } mon_state_t;

    mon_state_t       state_q, state_d;
    logic             start_d, done_d, inc, fault_entry;
    logic [1:0]       from_code;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       info_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        inc         = 1'b0;
        fault_entry = 1'b0;
        from_code   = IDLE;
        case (state_q)
            SYNC: begin
                if (state_in == IDLE) state_d = M_IDLE;
            end
            M_IDLE: begin
                from_code = IDLE;
                if (state_in == RUN) begin
                    state_d = M_RUN;
                    start_d = 1'b1;
                end else if (state_in != IDLE) begin
                    fault_entry = 1'b1;
                end
            end
            M_RUN: begin
                from_code = RUN;
                if (state_in == DONE) begin
                    state_d = M_DONE;
                    done_d  = 1'b1;
                end else begin
                    fault_entry = 1'b1;
                end
            end
            M_DONE: begin
                from_code = DONE;
                if (state_in == IDLE) begin
                    state_d = M_IDLE;
                    inc     = 1'b1;
                end else begin
                    fault_entry = 1'b1;
                end
            end
            FAULT: begin
                if (clear_err) state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
        if (fault_entry) state_d = FAULT;
    end

    // A clear that coincides with a completed run leaves the new run counted.
    always_comb begin
        count_d = run_count;
        if (count_clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            if (run_count == {CNT_W{1'b1}}) begin
                count_d = SAT ? run_count : '0;
            end else begin
                count_d = run_count + CNT_W'(1);
            end
        end
    end

    // The diagnostic is written only on entry to FAULT, so later bus activity cannot overwrite it.
    always_comb begin
        info_d = err_info;
        if (fault_entry) begin
            info_d = {from_code, state_in};
        end else if (state_q == FAULT && clear_err) begin
            info_d = 4'b0000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SYNC;
            run_start <= 1'b0;
            run_done  <= 1'b0;
            run_count <= '0;
            err       <= 1'b0;
            err_info  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            run_start <= start_d;
            run_done  <= done_d;
            run_count <= count_d;
            err       <= (state_d == FAULT);
            err_info  <= info_d;
        end
    end

    assign mon_state = state_q;

endmodule
